otter_mem_arbiter: RTL and testbench
====================================

// Module: otter_mem_arbiter
// PURPOSE
//  Shares one single-port synchronous memory between the MCU instruction-fetch port and data port.
//  Arbitrates fixed data-first priority with a starvation guard for fetch.
//  Sequences each access as a registered issue, a fixed read latency and a one-cycle ack pulse.
//  Sits between otter_mcu (imem_*/dmem_* side) and the unified memory macro.
// PARAMETERS
//  RD_LATENCY      1   cycles from m_en high to m_rdata valid; legal range 1..8
//  MAX_DATA_BURST  4   consecutive data grants allowed while i_req pending; legal range 1..15
// PORTS
//  clk      in   1   system clock, all logic on posedge
//  rst      in   1   synchronous, active-low reset (0 = reset)
//  i_req    in   1   fetch request; hold with i_addr stable until i_ack
//  i_addr   in   32  fetch byte address
//  i_rdata  out  32  fetch data, valid only while i_ack=1
//  i_ack    out  1   one-cycle pulse: fetch complete
//  d_req    in   1   data request; hold with d_* stable until d_ack
//  d_we     in   1   1 = store, 0 = load
//  d_strb   in   4   store byte strobes
//  d_addr   in   32  data byte address
//  d_wdata  in   32  store data
//  d_rdata  out  32  load data, valid only while d_ack=1
//  d_ack    out  1   one-cycle pulse: data access complete
//  m_en     out  1   memory access enable, high exactly one cycle per access
//  m_we     out  1   memory write enable, qualified by m_en
//  m_strb   out  4   memory byte strobes
//  m_addr   out  32  memory byte address
//  m_wdata  out  32  memory write data
//  m_rdata  in   32  memory read data, valid RD_LATENCY cycles after m_en
//  busy     out  1   1 when state != IDLE
// BEHAVIOUR
//  Reset (rst=0 at posedge)
//   - state=IDLE, streak=0.
//   - All outputs 0: m_*, i_ack/d_ack, i_rdata/d_rdata, busy.
//  State machine: IDLE -> ISSUE -> WAIT -> ACK -> IDLE. All outputs are registered.
//  IDLE, at edge T with any req high:
//   - Latch grant and fields; drive m_en=1 with m_we/m_strb/m_addr/m_wdata during cycle T+1 (ISSUE).
//   - Fetch grant drives m_we=0, m_strb=4'b0000, m_wdata=0.
//  ISSUE -> WAIT
//   - m_en, m_we, m_strb return to 0.
//   - Down-counter loads RD_LATENCY-1.
//   - Store skips WAIT: ISSUE -> ACK directly.
//  WAIT
//   - Counts down to 0.
//   - At the edge where m_rdata is valid, capture m_rdata into the granted port's rdata.
//   - Go to ACK.
//  ACK (one cycle)
//   - Granted port's ack=1; rdata holds the captured word (0 for stores).
//   - Requests are not sampled in ACK; next decision is the first IDLE edge.
//  Latency: req seen at edge T gives ack in cycle T+2+RD_LATENCY for loads/fetch, T+2 for stores.
//   - Min spacing between issues: RD_LATENCY+3 cycles (load), 3 cycles (store).
//  Arbitration in IDLE
//   - Only d_req: grant data. Only i_req: grant fetch.
//   - Both high: grant data unless streak == MAX_DATA_BURST, then grant fetch.
//   - streak increments on each data grant while i_req=1, saturating at MAX_DATA_BURST.
//   - streak clears on any fetch grant or any IDLE edge with i_req=0.
//  Boundaries
//   - d_we=1 with d_strb=0: still issues m_en with m_we=1, m_strb=0; acks normally.
//   - req dropped before ack: the in-flight access completes and acks anyway (requester error, no abort).
//   - rst=0 mid-access: immediate return to IDLE; captured data and pending ack are discarded; no ack after reset.
//   - Addresses pass through unmodified; alignment is the requester's responsibility.
// TESTING
//  1. RD_LATENCY=1; i_req, i_addr=0x100, mem[0x100]=0x00000013 -> m_en at T+1, i_ack at T+3, i_rdata=0x00000013.
//  2. i_req and d_req (load 0x2000=0xCAFEF00D) together -> d_ack first with 0xCAFEF00D, then fetch granted, i_ack 4 cycles later.
//  3. MAX_DATA_BURST=4; d_req and i_req both held -> grants D,D,D,D,I,D...; exactly 4 d_acks precede the first i_ack.
//  4. Store d_addr=0x40, d_strb=4'b0011, d_wdata=0x1234ABCD -> m_en/m_we=1, m_strb=0011 at T+1; d_ack at T+2, d_rdata=0; bytes 0x40-0x41 = CD,AB.
//  5. RD_LATENCY=3; rst=0 pulsed in WAIT during a fetch -> no i_ack ever; busy=0 and all outputs 0 next cycle; new fetch acks at T+5.
//  6. Back-to-back fetches with i_req held -> m_en pulses exactly RD_LATENCY+3 cycles apart; ack never asserts two cycles in a row.

Source files
------------

// File: rtl/otter_mem_arbiter_if.sv
// Bus bundle between otter_mcu, the arbiter and the unified memory macro.
// Fetch port:  i_req, i_addr        -> arbiter -> i_rdata, i_ack
// Data port:   d_req, d_we, d_strb, d_addr, d_wdata -> arbiter -> d_rdata, d_ack
// Memory side: arbiter -> m_en, m_we, m_strb, m_addr, m_wdata;  m_rdata -> arbiter
// Status:      busy (arbiter not idle)
// slave  = the arbiter's view; master = requesters plus memory (bench/MCU side).
interface otter_mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_strb;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        m_en;
    logic        m_we;
    logic [3:0]  m_strb;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_strb, d_addr, d_wdata, m_rdata,
        output i_rdata, i_ack, d_rdata, d_ack,
        output m_en, m_we, m_strb, m_addr, m_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_strb, d_addr, d_wdata, m_rdata,
        input  i_rdata, i_ack, d_rdata, d_ack,
        input  m_en, m_we, m_strb, m_addr, m_wdata, busy
    );
endinterface

// File: rtl/otter_mem_arbiter.sv
// Shares one single-port synchronous memory between the instruction-fetch
// port and the data port. Data has priority; after MAX_DATA_BURST consecutive
// data grants with a fetch pending, fetch is granted once.
// Each access: ISSUE (m_en for one cycle), WAIT (RD_LATENCY read cycles,
// skipped for stores), ACK (one-cycle ack pulse). All outputs registered.
// Ports: clk (posedge), rst (synchronous, active low), bus (slave modport).
//
// state | meaning
// IDLE  | waiting for a request; arbitration decision taken here
// ISSUE | m_en high, access presented to memory
// WAIT  | counting down read latency, capture m_rdata at terminal count
// ACK   | ack pulse on granted port with captured data
module otter_mem_arbiter #(
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned MAX_DATA_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    otter_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    localparam logic [2:0] CNT_LOAD  = 3'(RD_LATENCY - 1);
    localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);

    state_t      state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        gnt_data_q, gnt_data_d;
    logic        store_q, store_d;
    logic        m_en_q, m_en_d;
    logic        m_we_q, m_we_d;
    logic [3:0]  m_strb_q, m_strb_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic        i_ack_q, i_ack_d;
    logic        d_ack_q, d_ack_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        cnt_d      = cnt_q;
        gnt_data_d = gnt_data_q;
        store_d    = store_q;
        m_en_d     = 1'b0;
        m_we_d     = 1'b0;
        m_strb_d   = 4'b0000;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        i_ack_d    = 1'b0;
        d_ack_d    = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (!bus.i_req) streak_d = 4'd0;
                // Data wins unless a pending fetch has already waited out a full burst.
                if (bus.d_req && !(bus.i_req && streak_q == BURST_MAX)) begin
                    gnt_data_d = 1'b1;
                    store_d    = bus.d_we;
                    m_en_d     = 1'b1;
                    m_we_d     = bus.d_we;
                    m_strb_d   = bus.d_strb;
                    m_addr_d   = bus.d_addr;
                    m_wdata_d  = bus.d_wdata;
                    if (bus.i_req && streak_q < BURST_MAX) streak_d = streak_q + 4'd1;
                    state_d    = ISSUE;
                end else if (bus.i_req) begin
                    gnt_data_d = 1'b0;
                    store_d    = 1'b0;
                    m_en_d     = 1'b1;
                    m_addr_d   = bus.i_addr;
                    m_wdata_d  = 32'd0;
                    streak_d   = 4'd0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = CNT_LOAD;
                if (store_q) begin
                    d_ack_d = 1'b1;
                    state_d = ACK;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    if (gnt_data_q) begin
                        d_rdata_d = bus.m_rdata;
                        d_ack_d   = 1'b1;
                    end else begin
                        i_rdata_d = bus.m_rdata;
                        i_ack_d   = 1'b1;
                    end
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ACK: begin
                // rdata is only meaningful alongside ack; clear it on the way out.
                i_rdata_d = 32'd0;
                d_rdata_d = 32'd0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            streak_q   <= 4'd0;
            cnt_q      <= 3'd0;
            gnt_data_q <= 1'b0;
            store_q    <= 1'b0;
            m_en_q     <= 1'b0;
            m_we_q     <= 1'b0;
            m_strb_q   <= 4'b0000;
            m_addr_q   <= 32'd0;
            m_wdata_q  <= 32'd0;
            i_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            i_rdata_q  <= 32'd0;
            d_rdata_q  <= 32'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            cnt_q      <= cnt_d;
            gnt_data_q <= gnt_data_d;
            store_q    <= store_d;
            m_en_q     <= m_en_d;
            m_we_q     <= m_we_d;
            m_strb_q   <= m_strb_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            i_ack_q    <= i_ack_d;
            d_ack_q    <= d_ack_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.m_en    = m_en_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_strb  = m_strb_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.i_ack   = i_ack_q;
    assign bus.d_ack   = d_ack_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed bench for otter_mem_arbiter: instance A (RD_LATENCY=1, burst 4)
// with a word memory model, instance B (RD_LATENCY=3) with an
// address-derived read pipeline for the mid-access reset case.
module tb_otter_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic rst_b;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    otter_mem_arbiter_if bus_a ();
    otter_mem_arbiter_if bus_b ();

    otter_mem_arbiter #(.RD_LATENCY(1), .MAX_DATA_BURST(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    otter_mem_arbiter #(.RD_LATENCY(3), .MAX_DATA_BURST(4)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    // Memory A: word array, one-cycle read latency, byte-strobed writes.
    logic [31:0] mem_a [0:4095];
    logic [31:0] rd_a = 32'd0;
    assign bus_a.m_rdata = rd_a;

    always @(posedge clk) begin
        if (bus_a.m_en) begin
            if (bus_a.m_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus_a.m_strb[b])
                        mem_a[bus_a.m_addr[13:2]][b*8 +: 8] = bus_a.m_wdata[b*8 +: 8];
            end else begin
                rd_a <= mem_a[bus_a.m_addr[13:2]];
            end
        end
    end

    // Memory B: read data = addr ^ A5A50000, three-cycle latency.
    logic [31:0] pb0 = 32'd0, pb1 = 32'd0, pb2 = 32'd0;
    assign bus_b.m_rdata = pb2;
    always @(posedge clk) begin
        if (bus_b.m_en) pb0 <= bus_b.m_addr ^ 32'hA5A5_0000;
        pb1 <= pb0;
        pb2 <= pb1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack_a(output int n, output logic is_d);
        logic seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 30) begin
            tick();
            n++;
            if (bus_a.i_ack || bus_a.d_ack) seen = 1'b1;
        end
        is_d = bus_a.d_ack;
        chk("ack_timeout", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        int          n;
        logic        is_d;
        logic [5:0]  pat;
        int          last, pulses, dbl, acks;
        logic        prev_ack;

        for (int i = 0; i < 4096; i++) mem_a[i] = 32'd0;
        mem_a[12'h040] = 32'h0000_0013;   // 0x100
        mem_a[12'h041] = 32'h0000_0037;   // 0x104
        mem_a[12'h800] = 32'hCAFE_F00D;   // 0x2000
        mem_a[12'h010] = 32'hFFFF_FFFF;   // 0x40
        mem_a[12'h011] = 32'h1122_3344;   // 0x44

        rst = 1'b0; rst_b = 1'b0;
        bus_a.i_req = 0; bus_a.i_addr = 0; bus_a.d_req = 0; bus_a.d_we = 0;
        bus_a.d_strb = 0; bus_a.d_addr = 0; bus_a.d_wdata = 0;
        bus_b.i_req = 0; bus_b.i_addr = 0; bus_b.d_req = 0; bus_b.d_we = 0;
        bus_b.d_strb = 0; bus_b.d_addr = 0; bus_b.d_wdata = 0;
        tick(); tick();

        // Reset state
        chk("rst_busy",    {31'd0, bus_a.busy}, 0);
        chk("rst_m_en",    {31'd0, bus_a.m_en}, 0);
        chk("rst_m_we",    {31'd0, bus_a.m_we}, 0);
        chk("rst_m_strb",  {28'd0, bus_a.m_strb}, 0);
        chk("rst_m_addr",  bus_a.m_addr, 0);
        chk("rst_acks",    {30'd0, bus_a.i_ack, bus_a.d_ack}, 0);
        chk("rst_i_rdata", bus_a.i_rdata, 0);
        chk("rst_d_rdata", bus_a.d_rdata, 0);
        rst = 1'b1; rst_b = 1'b1;
        tick();

        // 1: single fetch, m_en at T+1, ack at T+3
        bus_a.i_req = 1; bus_a.i_addr = 32'h100;
        tick();
        chk("f1_m_en",   {31'd0, bus_a.m_en}, 1);
        chk("f1_m_we",   {31'd0, bus_a.m_we}, 0);
        chk("f1_m_strb", {28'd0, bus_a.m_strb}, 0);
        chk("f1_m_addr", bus_a.m_addr, 32'h100);
        chk("f1_busy",   {31'd0, bus_a.busy}, 1);
        tick();
        chk("f1_m_en_low", {31'd0, bus_a.m_en}, 0);
        chk("f1_no_ack",   {31'd0, bus_a.i_ack}, 0);
        tick();
        chk("f1_i_ack",   {31'd0, bus_a.i_ack}, 1);
        chk("f1_i_rdata", bus_a.i_rdata, 32'h13);
        bus_a.i_req = 0;
        tick();
        chk("f1_ack_drop", {31'd0, bus_a.i_ack}, 0);
        chk("f1_rdata_clr", bus_a.i_rdata, 0);
        chk("f1_idle", {31'd0, bus_a.busy}, 0);

        // 4: store with partial strobes
        bus_a.d_req = 1; bus_a.d_we = 1; bus_a.d_strb = 4'b0011;
        bus_a.d_addr = 32'h40; bus_a.d_wdata = 32'h1234_ABCD;
        tick();
        chk("st_m_en",    {31'd0, bus_a.m_en}, 1);
        chk("st_m_we",    {31'd0, bus_a.m_we}, 1);
        chk("st_m_strb",  {28'd0, bus_a.m_strb}, 4'b0011);
        chk("st_m_wdata", bus_a.m_wdata, 32'h1234_ABCD);
        tick();
        chk("st_d_ack",   {31'd0, bus_a.d_ack}, 1);
        chk("st_d_rdata", bus_a.d_rdata, 0);
        bus_a.d_req = 0;
        tick();
        chk("st_ack_drop", {31'd0, bus_a.d_ack}, 0);
        chk("st_mem", mem_a[12'h010], 32'hFFFF_ABCD);

        // Store with zero strobes still issues and acks, memory untouched
        bus_a.d_req = 1; bus_a.d_we = 1; bus_a.d_strb = 4'b0000;
        bus_a.d_addr = 32'h44; bus_a.d_wdata = 32'hDEAD_BEEF;
        tick();
        chk("st0_m_en",   {31'd0, bus_a.m_en}, 1);
        chk("st0_m_we",   {31'd0, bus_a.m_we}, 1);
        chk("st0_m_strb", {28'd0, bus_a.m_strb}, 0);
        tick();
        chk("st0_d_ack",  {31'd0, bus_a.d_ack}, 1);
        bus_a.d_req = 0; bus_a.d_we = 0;
        tick();
        chk("st0_mem", mem_a[12'h011], 32'h1122_3344);

        // Request dropped before ack still completes
        bus_a.i_req = 1; bus_a.i_addr = 32'h104;
        tick();
        bus_a.i_req = 0;
        tick(); tick();
        chk("drop_i_ack",   {31'd0, bus_a.i_ack}, 1);
        chk("drop_i_rdata", bus_a.i_rdata, 32'h37);
        tick();
        chk("drop_idle", {31'd0, bus_a.busy}, 0);

        // 2: simultaneous load and fetch, data first, fetch ack 4 cycles later
        bus_a.i_req = 1; bus_a.i_addr = 32'h104;
        bus_a.d_req = 1; bus_a.d_we = 0; bus_a.d_addr = 32'h2000;
        wait_ack_a(n, is_d);
        chk("both_first_is_d", {31'd0, is_d}, 1);
        chk("both_no_i_ack",   {31'd0, bus_a.i_ack}, 0);
        chk("both_d_rdata",    bus_a.d_rdata, 32'hCAFE_F00D);
        bus_a.d_req = 0;
        wait_ack_a(n, is_d);
        chk("both_fetch_gap",  n, 4);
        chk("both_i_rdata",    bus_a.i_rdata, 32'h37);
        bus_a.i_req = 0;
        tick();

        // 3: starvation guard, grants D,D,D,D,I,D
        pat = 6'b101111;
        bus_a.i_req = 1; bus_a.i_addr = 32'h100;
        bus_a.d_req = 1; bus_a.d_we = 0; bus_a.d_addr = 32'h2000;
        for (int k = 0; k < 6; k++) begin
            wait_ack_a(n, is_d);
            chk($sformatf("burst_order_%0d", k), {31'd0, is_d}, {31'd0, pat[k]});
            chk($sformatf("burst_single_ack_%0d", k), {31'd0, bus_a.i_ack & bus_a.d_ack}, 0);
            if (k == 4) chk("burst_i_rdata", bus_a.i_rdata, 32'h13);
        end
        bus_a.i_req = 0; bus_a.d_req = 0;
        tick();

        // 6: back-to-back fetches, m_en spacing RD_LATENCY+3
        bus_a.i_req = 1; bus_a.i_addr = 32'h100;
        last = -1; pulses = 0; dbl = 0; prev_ack = 1'b0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (bus_a.m_en) begin
                if (last >= 0) chk("b2b_spacing", c - last, 4);
                last = c;
                pulses++;
            end
            if ((bus_a.i_ack || bus_a.d_ack) && prev_ack) dbl++;
            prev_ack = bus_a.i_ack || bus_a.d_ack;
            if (c == 15) bus_a.i_req = 0;
        end
        chk("b2b_pulses", pulses, 4);
        chk("b2b_ack_double", dbl, 0);

        // 5: RD_LATENCY=3, reset pulsed during WAIT
        bus_b.i_req = 1; bus_b.i_addr = 32'h300;
        tick();
        chk("rw_m_en", {31'd0, bus_b.m_en}, 1);
        tick();
        chk("rw_busy_wait", {31'd0, bus_b.busy}, 1);
        rst_b = 1'b0; bus_b.i_req = 0;
        tick();
        chk("rw_busy",    {31'd0, bus_b.busy}, 0);
        chk("rw_m_en0",   {31'd0, bus_b.m_en}, 0);
        chk("rw_m_addr",  bus_b.m_addr, 0);
        chk("rw_i_ack",   {31'd0, bus_b.i_ack}, 0);
        chk("rw_i_rdata", bus_b.i_rdata, 0);
        rst_b = 1'b1;
        acks = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus_b.i_ack) acks++;
        end
        chk("rw_no_ack_after_rst", acks, 0);
        bus_b.i_req = 1; bus_b.i_addr = 32'h200;
        acks = 0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (bus_b.i_ack) acks++;
        end
        chk("rw_early_ack", acks, 0);
        tick();
        chk("rw_i_ack_t5",  {31'd0, bus_b.i_ack}, 1);
        chk("rw_i_rdata_t5", bus_b.i_rdata, 32'hA5A5_0200);
        bus_b.i_req = 0;
        tick();
        chk("rw_ack_drop", {31'd0, bus_b.i_ack}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
